// File: rtl/fir_seq_pkg.sv
// Shared opcode/register constants, sequencer state encoding and the
// state-to-micro-op decode used by fir_sequencer.
package fir_seq_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  localparam logic [3:0] R_ACC = 4'd0;
  localparam logic [3:0] R_S1  = 4'd1;
  localparam logic [3:0] R_S2  = 4'd2;
  localparam logic [3:0] R_S3  = 4'd3;
  localparam logic [3:0] R_S4  = 4'd4;
  localparam logic [3:0] R_C0  = 4'd5;
  localparam logic [3:0] R_C1  = 4'd6;
  localparam logic [3:0] R_C2  = 4'd7;
  localparam logic [3:0] R_C3  = 4'd8;
  localparam logic [3:0] R_TMP = 4'd10;

  // SH3..A3 must stay contiguous: the sample sequence advances by +1.
  typedef enum logic [3:0] {
    IDLE, SH3, SH2, SH1, STORE, M0, M1, A1, M2, A2, M3, A3, LDC, ERROR
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
  } uop_t;

  function automatic uop_t decode(state_t s, logic hpf, logic [1:0] cidx);
    uop_t       u;
    logic [2:0] acc_op;
    acc_op = hpf ? OP_SUB : OP_ADD;
    u      = '0;
    case (s)
      SH3:     u = '{op: OP_COPY,  src1: R_S3,  src2: R_ACC, dest: R_S4};
      SH2:     u = '{op: OP_COPY,  src1: R_S2,  src2: R_ACC, dest: R_S3};
      SH1:     u = '{op: OP_COPY,  src1: R_S1,  src2: R_ACC, dest: R_S2};
      STORE:   u = '{op: OP_LOAD1, src1: R_ACC, src2: R_ACC, dest: R_S1};
      M0:      u = '{op: OP_MUL,   src1: R_S1,  src2: R_C0,  dest: R_ACC};
      M1:      u = '{op: OP_MUL,   src1: R_S2,  src2: R_C1,  dest: R_TMP};
      A1:      u = '{op: acc_op,   src1: R_ACC, src2: R_TMP, dest: R_ACC};
      M2:      u = '{op: OP_MUL,   src1: R_S3,  src2: R_C2,  dest: R_TMP};
      A2:      u = '{op: OP_ADD,   src1: R_ACC, src2: R_TMP, dest: R_ACC};
      M3:      u = '{op: OP_MUL,   src1: R_S4,  src2: R_C3,  dest: R_TMP};
      A3:      u = '{op: acc_op,   src1: R_ACC, src2: R_TMP, dest: R_ACC};
      LDC:     u = '{op: OP_LOAD2, src1: R_ACC, src2: R_ACC, dest: R_C0 + {2'b00, cidx}};
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Sequencer <-> datapath bus: request levels in, micro-op and status out.
interface fir_sequencer_if;
  logic       data_ready;
  logic       load_coeff;
  logic       overflow;
  logic [2:0] op;
  logic [3:0] src1;
  logic [3:0] src2;
  logic [3:0] dest;
  logic       modwait;
  logic       cnt_up;
  logic       clear;
  logic       err;
  logic [1:0] coeff_idx;

  modport master (
    input  data_ready, load_coeff, overflow,
    output op, src1, src2, dest, modwait, cnt_up, clear, err, coeff_idx
  );

  modport slave (
    output data_ready, load_coeff, overflow,
    input  op, src1, src2, dest, modwait, cnt_up, clear, err, coeff_idx
  );
endinterface

// File: rtl/fir_sequencer_rise_detect.sv
// Rising-edge detector against a registered copy of the input level.
module rise_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev <= 1'b0;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/fir_sequencer.sv
// 4-tap FIR control sequencer: turns sample/coefficient requests into
// datapath micro-ops, with one-deep request queuing and overrun/overflow error.
module fir_sequencer
  import fir_seq_pkg::*;
#(
  parameter int HIGH_PASS_FILTER = 0
) (
  input logic             clk,
  input logic             n_rst,
  fir_sequencer_if.master bus
);

  localparam logic HPF = (HIGH_PASS_FILTER != 0);

  state_t     state;
  logic       dr_rise, lc_rise;
  logic       sample_pend, coeff_pend, overrun;
  logic       sp_n, cp_n, ov_n;
  logic       ovf_win;
  logic [1:0] coeff_idx;
  uop_t       uop;

  rise_detect u_dr_rise (.clk(clk), .n_rst(n_rst), .sig(bus.data_ready), .rise(dr_rise));
  rise_detect u_lc_rise (.clk(clk), .n_rst(n_rst), .sig(bus.load_coeff), .rise(lc_rise));

  // Flags as they stand once this cycle's edges are recorded while busy.
  assign sp_n    = sample_pend | dr_rise;
  assign ov_n    = overrun | (sample_pend & dr_rise);
  assign cp_n    = coeff_pend | lc_rise;
  assign ovf_win = (state >= M0) && (state <= A3);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      sample_pend <= 1'b0;
      coeff_pend  <= 1'b0;
      overrun     <= 1'b0;
      coeff_idx   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_pend | dr_rise) begin
            state       <= SH3;
            sample_pend <= 1'b0;
            coeff_pend  <= cp_n;
          end else if (cp_n) begin
            state      <= LDC;
            coeff_pend <= 1'b0;
          end
        end
        ERROR: begin
          if (dr_rise) begin
            state      <= SH3;
            overrun    <= 1'b0;
            coeff_pend <= cp_n;
          end else if (lc_rise) begin
            state      <= LDC;
            overrun    <= 1'b0;
            coeff_pend <= 1'b0;
          end
        end
        default: begin
          sample_pend <= sp_n;
          coeff_pend  <= cp_n;
          overrun     <= ov_n;
          if (state == LDC) coeff_idx <= coeff_idx + 2'd1;
          if (ovf_win && bus.overflow) begin
            state       <= ERROR;
            sample_pend <= 1'b0;
            coeff_pend  <= 1'b0;
          end else if (state == A3 || state == LDC) begin
            if (ov_n) begin
              state       <= ERROR;
              sample_pend <= 1'b0;
              coeff_pend  <= 1'b0;
            end else if (sp_n) begin
              state       <= SH3;
              sample_pend <= 1'b0;
            end else if (cp_n) begin
              state      <= LDC;
              coeff_pend <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= state_t'(state + 4'd1);
          end
        end
      endcase
    end
  end

  assign uop           = decode(state, HPF, coeff_idx);
  assign bus.op        = uop.op;
  assign bus.src1      = uop.src1;
  assign bus.src2      = uop.src2;
  assign bus.dest      = uop.dest;
  assign bus.modwait   = (state != IDLE) && (state != ERROR);
  assign bus.cnt_up    = (state == STORE);
  assign bus.clear     = (state == LDC) && (coeff_idx == 2'd0);
  assign bus.err       = (state == ERROR);
  assign bus.coeff_idx = coeff_idx;

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench: LPF and HPF sequencers driven in lockstep, checked every cycle
// against a step-indexed behavioural model of the request/sequence rules.
module tb_fir_sequencer;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic dr = 1'b0, lc = 1'b0, ovf = 1'b0;

  fir_sequencer_if lpf_if ();
  fir_sequencer_if hpf_if ();

  assign lpf_if.data_ready = dr;
  assign lpf_if.load_coeff = lc;
  assign lpf_if.overflow   = ovf;
  assign hpf_if.data_ready = dr;
  assign hpf_if.load_coeff = lc;
  assign hpf_if.overflow   = ovf;

  fir_sequencer #(.HIGH_PASS_FILTER(0)) u_lpf (.clk(clk), .n_rst(n_rst), .bus(lpf_if.master));
  fir_sequencer #(.HIGH_PASS_FILTER(1)) u_hpf (.clk(clk), .n_rst(n_rst), .bus(hpf_if.master));

  always #5 clk = ~clk;

  logic [20:0] obs_l, obs_h;
  assign obs_l = {lpf_if.op, lpf_if.src1, lpf_if.src2, lpf_if.dest, lpf_if.modwait,
                  lpf_if.cnt_up, lpf_if.clear, lpf_if.err, lpf_if.coeff_idx};
  assign obs_h = {hpf_if.op, hpf_if.src1, hpf_if.src2, hpf_if.dest, hpf_if.modwait,
                  hpf_if.cnt_up, hpf_if.clear, hpf_if.err, hpf_if.coeff_idx};

  int n_chk = 0, n_err = 0;
  int mw_cnt = 0, cu_cnt = 0, clr_cnt = 0;

  // Model: mpos -1 idle, 0..10 sample step, 11 coefficient load, 12 error.
  int mpos = -1, mcidx = 0;
  bit msp = 0, mcp = 0, mov = 0, mdrp = 0, mlcp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] seq_uop(int k, bit hpf);
    logic [2:0] acc;
    acc = hpf ? 3'd5 : 3'd4;
    case (k)
      0:  return {3'd1, 4'd3, 4'd0,  4'd4};
      1:  return {3'd1, 4'd2, 4'd0,  4'd3};
      2:  return {3'd1, 4'd1, 4'd0,  4'd2};
      3:  return {3'd2, 4'd0, 4'd0,  4'd1};
      4:  return {3'd6, 4'd1, 4'd5,  4'd0};
      5:  return {3'd6, 4'd2, 4'd6,  4'd10};
      6:  return {acc,  4'd0, 4'd10, 4'd0};
      7:  return {3'd6, 4'd3, 4'd7,  4'd10};
      8:  return {3'd4, 4'd0, 4'd10, 4'd0};
      9:  return {3'd6, 4'd4, 4'd8,  4'd10};
      default: return {acc, 4'd0, 4'd10, 4'd0};
    endcase
  endfunction

  function automatic logic [20:0] exp_vec(bit hpf);
    logic [14:0] u;
    u = '0;
    if (mpos >= 0 && mpos <= 10) u = seq_uop(mpos, hpf);
    else if (mpos == 11)         u = {3'd3, 4'd0, 4'd0, 4'(5 + mcidx)};
    return {u, (mpos >= 0 && mpos <= 11), (mpos == 3), (mpos == 11 && mcidx == 0),
            (mpos == 12), 2'(mcidx)};
  endfunction

  task automatic model_step(input bit d, input bit l, input bit o);
    bit de, le;
    de = d & !mdrp;
    le = l & !mlcp;
    mdrp = d;
    mlcp = l;
    if (mpos == -1) begin
      if (msp || de) begin mpos = 0; msp = 0; mcp = mcp | le; end
      else if (mcp || le) begin mpos = 11; mcp = 0; end
    end else if (mpos == 12) begin
      if (de) begin mpos = 0; mov = 0; mcp = mcp | le; end
      else if (le) begin mpos = 11; mov = 0; end
    end else begin
      if (de) begin if (msp) mov = 1; else msp = 1; end
      if (le) mcp = 1;
      if (mpos >= 4 && mpos <= 10 && o) begin
        mpos = 12; msp = 0; mcp = 0;
      end else if (mpos == 10 || mpos == 11) begin
        if (mpos == 11) mcidx = (mcidx + 1) % 4;
        if (mov)      begin mpos = 12; msp = 0; mcp = 0; end
        else if (msp) begin mpos = 0;  msp = 0; end
        else if (mcp) begin mpos = 11; mcp = 0; end
        else mpos = -1;
      end else begin
        mpos++;
      end
    end
  endtask

  task automatic model_reset();
    mpos = -1; mcidx = 0; msp = 0; mcp = 0; mov = 0; mdrp = 0; mlcp = 0;
  endtask

  task automatic cyc(input bit d, input bit l, input bit o);
    @(negedge clk);
    check("lpf_outputs", obs_l, exp_vec(0));
    check("hpf_outputs", obs_h, exp_vec(1));
    mw_cnt  += int'(lpf_if.modwait);
    cu_cnt  += int'(lpf_if.cnt_up);
    clr_cnt += int'(lpf_if.clear);
    dr = d; lc = l; ovf = o;
    model_step(d, l, o);
  endtask

  task automatic clr_counts();
    mw_cnt = 0; cu_cnt = 0; clr_cnt = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mpos != -1 && mpos != 12; i++) cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    dr = 0; lc = 0; ovf = 0;
    #1;
    check("async_rst_lpf", obs_l, 21'd0);
    check("async_rst_hpf", obs_h, 21'd0);
    check("async_rst_cidx", lpf_if.coeff_idx, 2'd0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_lpf", obs_l, 21'd0);
    check("reset_hpf", obs_h, 21'd0);
    n_rst = 1'b1;

    // four coefficient loads from reset
    clr_counts();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    end
    check("coeff_clear_count", clr_cnt, 1);
    check("coeff_idx_wrap", lpf_if.coeff_idx, 2'd0);

    // single sample: full 11-step trace
    clr_counts();
    cyc(1, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0);
    check("sample_modwait_cycles", mw_cnt, 11);
    check("sample_cnt_up_pulses", cu_cnt, 1);
    cyc(0, 0, 0);

    // overflow in M1 -> error, then recovery on a fresh edge
    cyc(1, 0, 0);
    for (int i = 0; i < 20 && mpos != 12; i++) cyc(1, 0, mpos == 5);
    cyc(1, 0, 0);
    check("ovf_err", lpf_if.err, 1'b1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("err_exit_sh3", {lpf_if.err, lpf_if.op, lpf_if.dest}, {1'b0, 3'd1, 4'd4});
    drain();

    // two extra edges during a sequence -> overrun error after A3
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    check("overrun_err", lpf_if.err, 1'b1);
    // one extra edge -> back-to-back sequence
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 0);
    drain();

    // simultaneous edges in idle, then async reset in M2
    cyc(1, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 20 && mpos != 7; i++) cyc(0, 0, 0);
    async_reset();
    cyc(0, 0, 0);

    // randomized levels and rare overflow
    begin
      bit d, l, o;
      d = 0; l = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(5) == 0) d = ~d;
        if ($urandom_range(9) == 0) l = ~l;
        o = ($urandom_range(39) == 0);
        cyc(d, l, o);
        if (i == 2000) begin
          async_reset();
          d = 0; l = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
